// File: rtl/cpu_datapath.sv
// Execution datapath: general register file, RA/RC, a shared internal bus and a small
// logic ALU, all driven one instruction per clock by decoded control strobes.
module cpu_datapath #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       regSel,
  input  logic [2:0]       aluSel,
  input  logic             Rin,
  input  logic             Rout,
  input  logic             RAin,
  input  logic             RCout,
  input  logic             genConst,
  input  logic [2:0]       dbgSel,
  output logic [WIDTH-1:0] dbgVal,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] raVal,
  output logic [WIDTH-1:0] rcVal,
  output logic             zero,
  output logic             busErr
);

  logic [WIDTH-1:0] r_reg [NREGS];
  logic [WIDTH-1:0] ra_reg;
  logic [WIDTH-1:0] rc_reg;
  logic             zero_reg;
  logic             bus_err_reg;

  logic [1:0]       drv_count;
  logic             conflict;
  logic             rc_we;
  logic             ra_we;
  logic             reg_we;
  logic [WIDTH-1:0] const_val;
  logic [WIDTH-1:0] alu_next;

  assign drv_count = {1'b0, Rout} + {1'b0, RCout} + {1'b0, genConst};
  assign conflict  = (drv_count > 2'd1);
  assign const_val = {{(WIDTH-3){1'b0}}, regSel};

  // A contested bus reads as zero so nothing downstream latches garbage.
  always_comb begin
    bus = '0;
    if (!conflict) begin
      if (Rout)
        bus = r_reg[regSel];
      else if (RCout)
        bus = rc_reg;
      else if (genConst)
        bus = const_val;
    end
  end

  always_comb begin
    alu_next = bus;
    case (aluSel)
      3'd0:    alu_next = bus;
      3'd1:    alu_next = ~bus;
      3'd2:    alu_next = ra_reg & bus;
      3'd3:    alu_next = ra_reg | bus;
      3'd4:    alu_next = ra_reg ^ bus;
      default: alu_next = bus;
    endcase
  end

  assign rc_we  = ((Rout & ~RAin) | genConst) & ~conflict & (aluSel <= 3'd4);
  assign ra_we  = RAin & ~conflict;
  assign reg_we = Rin & ~conflict;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi = gi + 1) begin : g_regs
      localparam logic [2:0] IDX = 3'(gi);
      always_ff @(posedge clk) begin
        if (rst)
          r_reg[gi] <= '0;
        else if (reg_we && (regSel == IDX))
          r_reg[gi] <= bus;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_reg      <= '0;
      rc_reg      <= '0;
      zero_reg    <= 1'b1;
      bus_err_reg <= 1'b0;
    end else begin
      if (ra_we)
        ra_reg <= bus;
      if (rc_we) begin
        rc_reg   <= alu_next;
        zero_reg <= (alu_next == '0);
      end
      if (conflict)
        bus_err_reg <= 1'b1;
    end
  end

  assign dbgVal = r_reg[dbgSel];
  assign raVal  = ra_reg;
  assign rcVal  = rc_reg;
  assign zero   = zero_reg;
  assign busErr = bus_err_reg;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: a per-cycle behavioural model checked on every falling
// edge, plus literal expectations taken from hand-worked instruction sequences.
module tb_cpu_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] regSel = '0;
  logic [2:0] aluSel = '0;
  logic       Rin = 1'b0, Rout = 1'b0, RAin = 1'b0, RCout = 1'b0, genConst = 1'b0;
  logic [2:0] dbgSel = '0;
  logic [7:0] dbgVal, bus, raVal, rcVal;
  logic       zero, busErr;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: what the architectural registers must hold after each edge.
  int  m_r [8];
  int  m_ra, m_rc;
  bit  m_zero, m_err, m_valid;
  logic [7:0] seen_bus;

  cpu_datapath #(.WIDTH(8), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .regSel(regSel), .aluSel(aluSel),
    .Rin(Rin), .Rout(Rout), .RAin(RAin), .RCout(RCout), .genConst(genConst),
    .dbgSel(dbgSel), .dbgVal(dbgVal), .bus(bus), .raVal(raVal), .rcVal(rcVal),
    .zero(zero), .busErr(busErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected bus value from the current strobes and the model's registers.
  function automatic int model_bus();
    int n;
    n = int'(Rout) + int'(RCout) + int'(genConst);
    if (n != 1) return 0;
    if (Rout) return m_r[regSel];
    if (RCout) return m_rc;
    return int'(regSel);
  endfunction

  // Compare process: check everything visible, then advance the model past the coming edge.
  initial begin
    int b, res, n;
    bit conf;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("bus", bus, model_bus());
        chk("dbgVal", dbgVal, m_r[dbgSel]);
        chk("raVal", raVal, m_ra);
        chk("rcVal", rcVal, m_rc);
        chk("zero", zero, m_zero);
        chk("busErr", busErr, m_err);
      end
      if (rst) begin
        foreach (m_r[i]) m_r[i] = 0;
        m_ra = 0; m_rc = 0; m_zero = 1; m_err = 0; m_valid = 1;
      end else begin
        n    = int'(Rout) + int'(RCout) + int'(genConst);
        conf = (n > 1);
        b    = model_bus();
        case (aluSel)
          3'd1:    res = (~b) & 8'hFF;
          3'd2:    res = m_ra & b;
          3'd3:    res = m_ra | b;
          3'd4:    res = m_ra ^ b;
          default: res = b;
        endcase
        if (conf) m_err = 1;
        if (!conf && ((Rout && !RAin) || genConst) && aluSel <= 3'd4) begin
          m_rc = res; m_zero = (res == 0);
        end
        if (!conf && RAin) m_ra = b;
        if (!conf && Rin) m_r[regSel] = b;
      end
    end
  end

  // One instruction: drive strobes just after an edge, return just after the next edge.
  task automatic cyc(input bit r, input int sel, input int alu,
                     input bit rin, input bit rout, input bit rain, input bit rcout, input bit gc);
    rst = r; regSel = 3'(sel); aluSel = 3'(alu);
    Rin = rin; Rout = rout; RAin = rain; RCout = rcout; genConst = gc;
    #1 seen_bus = bus;
    $display("t=%0t rst=%0d sel=%0d alu=%0d Rin=%0d Rout=%0d RAin=%0d RCout=%0d gc=%0d bus=%02h",
             $time, r, sel, alu, rin, rout, rain, rcout, gc, seen_bus);
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset with random strobes; reset must win over all of them.
    repeat (2) cyc(1, $urandom_range(7), $urandom_range(7), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom));
    chk("rst_ra", raVal, 0);
    chk("rst_rc", rcVal, 0);
    chk("rst_zero", zero, 1);
    chk("rst_err", busErr, 0);
    for (int i = 0; i < 8; i++) begin
      dbgSel = 3'(i);
      nop();
      chk("rst_reg", dbgVal, 0);
    end

    // Constant and store
    cyc(0, 5, 0, 0, 0, 0, 0, 1);
    chk("const_rc", rcVal, 8'h05);
    chk("const_zero", zero, 0);
    cyc(0, 2, 0, 1, 0, 0, 1, 0);
    dbgSel = 3'd2; #1;
    chk("store_r2", dbgVal, 8'h05);

    // Logic ops: R1=6, R2=3, RA=6
    cyc(0, 6, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 1, 0, 0, 1, 0);
    cyc(0, 3, 0, 0, 0, 0, 0, 1);
    cyc(0, 2, 0, 1, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 1, 0, 0);
    chk("ra_load", raVal, 8'h06);
    chk("ra_no_rc", rcVal, 8'h03);
    cyc(0, 2, 2, 0, 1, 0, 0, 0);
    chk("and", rcVal, 8'h02);
    cyc(0, 2, 3, 0, 1, 0, 0, 0);
    chk("or", rcVal, 8'h07);
    cyc(0, 2, 4, 0, 1, 0, 0, 0);
    chk("xor", rcVal, 8'h05);
    cyc(0, 2, 1, 0, 1, 0, 0, 0);
    chk("not", rcVal, 8'hFC);

    // Zero flag
    cyc(0, 1, 4, 0, 1, 0, 0, 0);
    chk("xor_zero_rc", rcVal, 8'h00);
    chk("xor_zero", zero, 1);
    nop();
    chk("nop_zero", zero, 1);
    chk("nop_rc", rcVal, 8'h00);

    // Conflict: Rout + genConst with Rin
    cyc(0, 1, 0, 1, 1, 0, 0, 1);
    chk("conf_bus", seen_bus, 8'h00);
    chk("conf_err", busErr, 1);
    dbgSel = 3'd1; #1;
    chk("conf_r1", dbgVal, 8'h06);
    chk("conf_ra", raVal, 8'h06);
    chk("conf_rc", rcVal, 8'h00);
    for (int i = 0; i < 5; i++) begin
      nop();
      chk("err_sticky", busErr, 1);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("err_clear", busErr, 0);

    // Reserved op and self-copy: R3=4, RC=2
    cyc(0, 4, 0, 0, 0, 0, 0, 1);
    cyc(0, 3, 0, 1, 0, 0, 1, 0);
    cyc(0, 2, 0, 0, 0, 0, 0, 1);
    cyc(0, 3, 6, 0, 1, 0, 0, 0);
    chk("rsvd_rc", rcVal, 8'h02);
    chk("rsvd_zero", zero, 0);
    cyc(0, 3, 7, 1, 1, 0, 0, 0);
    dbgSel = 3'd3; #1;
    chk("selfcopy_r3", dbgVal, 8'h04);
    chk("selfcopy_err", busErr, 0);

    // Random mix, including occasional mid-sequence reset (genConst kept apart from RAin)
    for (int i = 0; i < 60; i++) begin
      bit ra_s, gc_s;
      ra_s = 1'($urandom);
      gc_s = ra_s ? 1'b0 : 1'($urandom);
      dbgSel = 3'($urandom);
      cyc(($urandom_range(15) == 0), $urandom_range(7), $urandom_range(7), 1'($urandom),
          1'($urandom), ra_s, ($urandom_range(3) == 0), gc_s);
    end
    nop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Execution datapath directly downstream of the control unit.
- Consumes the decoded per-instruction control strobes (regSel, aluSel, Rin, Rout, RAin, RCout, genConst) and performs the register transfers and ALU operations they encode, one instruction per clock.
- Holds the general register file, operand register RA and result register RC, and exposes the internal bus, a zero flag and a bus-conflict error for debug and verification.

Parameters:
- WIDTH, 8, data width of registers, bus and ALU.
- NREGS, 8, number of general registers; fixed at 8 because regSel is 3 bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- regSel  in  3  general register index; also the immediate value when genConst=1.
- aluSel  in  3  ALU function: 0 pass, 1 not, 2 and, 3 or, 4 xor, 5-7 reserved.
- Rin  in  1  write bus into R[regSel].
- Rout  in  1  drive R[regSel] onto bus.
- RAin  in  1  load bus into RA.
- RCout  in  1  drive RC onto bus.
- genConst  in  1  drive zero-extended regSel onto bus.
- dbgSel  in  3  debug read index.
- dbgVal  out  WIDTH  R[dbgSel], combinational.
- bus  out  WIDTH  current internal bus value, combinational.
- raVal  out  WIDTH  RA contents.
- rcVal  out  WIDTH  RC contents.
- zero  out  1  registered; 1 when the last RC write was 0.
- busErr  out  1  sticky; set on any bus driver conflict.

Behaviour:
- Reset (rst=1 at clk edge): R0-R7=0, RA=0, RC=0, zero=1, busErr=0. Reset takes precedence over every strobe in the same cycle.
- Bus drivers: Rout -> R[regSel]; RCout -> RC; genConst -> {WIDTH-3 zeros, regSel}.
  - No driver -> bus=0.
  - More than one driver -> conflict. Bus reads 0, all writes that cycle (R, RA, RC, zero) are suppressed, and busErr<=1. busErr stays set until rst.
- ALU result (combinational, from bus B and RA):
  - 0: B
  - 1: ~B
  - 2: RA&B
  - 3: RA|B
  - 4: RA^B
  - All results are WIDTH wide; no carry.
- RC write enable = ((Rout & ~RAin) | genConst) & ~conflict & (aluSel<=4).
  - On enable: RC <= ALU result; zero <= (result==0).
  - aluSel 5-7: RC and zero hold.
- RA write: RAin & ~conflict -> RA <= bus. RC does not update when RAin=1.
- Register write: Rin & ~conflict -> R[regSel] <= bus.
  - Rin together with Rout is a self-copy: the register holds its value and the write is legal.
- Same-cycle read/write: all reads (bus, ALU operands) use pre-edge values; the new value is visible from the next cycle. No internal forwarding is required because the control unit issues one instruction per cycle.
- Latency: each instruction completes at the clock edge that samples its strobes. Results are visible on rcVal/raVal/dbgVal one cycle later.
- All strobes low (NOP): no state changes.
- Reset mid-sequence: discards any in-flight result and returns state to the reset values; execution resumes on the next cycle.

Test Plan:
- Reset check: hold rst for 2 cycles with random strobes -> R0-R7=0, RA=0, RC=0, zero=1, busErr=0.
- Constant and store:
  - genConst, regSel=5, aluSel=0 -> rcVal=0x05, zero=0.
  - Next cycle RCout+Rin, regSel=2 -> dbgSel=2 gives 0x05.
- Logic ops:
  - Set R1=0x06 and R2=0x03 via const/RC moves.
  - Rout+RAin regSel=1 -> RA=0x06.
  - Rout aluSel=2 regSel=2 -> RC=0x02; aluSel=3 -> 0x07; aluSel=4 -> 0x05.
  - aluSel=1 regSel=2 -> RC=0xFC.
- Zero flag: RA=0x06, R1=0x06, Rout aluSel=4 regSel=1 -> RC=0x00, zero=1.
  - Following NOP -> zero stays 1 and RC stays 0.
- Conflict: Rout+genConst with Rin in the same cycle -> busErr=1, R/RA/RC unchanged, bus=0.
  - busErr stays 1 through 5 NOPs; cleared only by rst.
- Reserved op and self-copy:
  - aluSel=6 with Rout -> RC holds.
  - Rin+Rout regSel=3 (R3=0x04) -> R3 stays 0x04, busErr=0.
